// File: rtl/spart_fifo_core_if.sv
// spart_fifo_core_if: processor-side bus of the FIFO SPART.
// master drives iocs/iorw/ioaddr/wdata; slave returns rdata/rda/tbr/irq.
interface spart_fifo_core_if;
  logic        iocs;
  logic        iorw;
  logic [1:0]  ioaddr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        rda;
  logic        tbr;
  logic        irq;

  modport master (
    output iocs, iorw, ioaddr, wdata,
    input  rdata, rda, tbr, irq
  );

  modport slave (
    input  iocs, iorw, ioaddr, wdata,
    output rdata, rda, tbr, irq
  );
endinterface

// File: rtl/spart_fifo_core.sv
// spart_fifo_core: full-duplex SPART with baud divisor and TX/RX FIFOs.
// Ports: clk, rst (sync, active-high), bus (slave: iocs/iorw/ioaddr/wdata,
// rdata/rda/tbr/irq), txd (idle high), rxd (async serial in).
// Define SPART_PARITY_EN to add an even-parity bit on TX and RX.
module spart_fifo_core #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned TX_DEPTH    = 8,
  parameter int unsigned RX_DEPTH    = 8,
  parameter int unsigned OVERSAMPLE  = 16,
  parameter logic [15:0] DEFAULT_DIV = 16'd650
) (
  input  logic             clk,
  input  logic             rst,
  spart_fifo_core_if.slave bus,
  output logic             txd,
  input  logic             rxd
);

  localparam int unsigned TAW = $clog2(TX_DEPTH);
  localparam int unsigned RAW = $clog2(RX_DEPTH);
  localparam int unsigned OSW = $clog2(OVERSAMPLE);
  localparam int unsigned BW  = $clog2(DATA_W);

  localparam logic [OSW-1:0] OS_LAST = OSW'(OVERSAMPLE - 1);
  localparam logic [OSW-1:0] OS_MID  = OSW'(OVERSAMPLE / 2 - 1);
  localparam logic [BW-1:0]  B_LAST  = BW'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PAR, S_STOP
  } st_e;

`ifdef SPART_PARITY_EN
  localparam st_e AFTER_DATA = S_PAR;
`else
  localparam st_e AFTER_DATA = S_STOP;
`endif

  // bus decode
  logic wr, rd;
  logic wr_data, wr_stat, wr_div, wr_ctrl;
  logic rd_data;

  assign wr      = bus.iocs & ~bus.iorw;
  assign rd      = bus.iocs & bus.iorw;
  assign wr_data = wr & (bus.ioaddr == 2'd0);
  assign wr_stat = wr & (bus.ioaddr == 2'd1);
  assign wr_div  = wr & (bus.ioaddr == 2'd2);
  assign wr_ctrl = wr & (bus.ioaddr == 2'd3);
  assign rd_data = rd & (bus.ioaddr == 2'd0);

  // registers
  logic [15:0] div_q, div_d;
  logic [15:0] bcnt_q, bcnt_d;
  logic [1:0]  ctrl_q, ctrl_d;
  logic [15:0] rdata_q, rdata_d;
  logic        irq_q, irq_d;
  logic        ovr_q, ovr_d;
  logic        fe_q, fe_d;
  logic        txo_q, txo_d;
  logic        pe_q, pe_d;
  logic        rx_s1_q, rx_s1_d;
  logic        rx_s2_q, rx_s2_d;
  logic        rx_prev_q, rx_prev_d;
  logic        tick;

  assign tick = (bcnt_q == 16'd0);

  // TX FIFO
  logic [DATA_W-1:0] tx_mem [TX_DEPTH];
  logic [TAW:0]      tx_wp_q, tx_wp_d;
  logic [TAW:0]      tx_rp_q, tx_rp_d;
  logic              tx_empty, tx_full;
  logic              tx_push, tx_pop;
  logic [DATA_W-1:0] tx_head;

  assign tx_empty = (tx_wp_q == tx_rp_q);
  assign tx_full  = (tx_wp_q[TAW] != tx_rp_q[TAW]) &&
                    (tx_wp_q[TAW-1:0] == tx_rp_q[TAW-1:0]);
  assign tx_head  = tx_mem[tx_rp_q[TAW-1:0]];
  assign tx_push  = wr_data & ~tx_full;

  // RX FIFO
  logic [DATA_W-1:0] rx_mem [RX_DEPTH];
  logic [RAW:0]      rx_wp_q, rx_wp_d;
  logic [RAW:0]      rx_rp_q, rx_rp_d;
  logic              rx_empty, rx_full;
  logic              rx_push, rx_pop;
  logic [DATA_W-1:0] rx_head;

  assign rx_empty = (rx_wp_q == rx_rp_q);
  assign rx_full  = (rx_wp_q[RAW] != rx_rp_q[RAW]) &&
                    (rx_wp_q[RAW-1:0] == rx_rp_q[RAW-1:0]);
  assign rx_head  = rx_mem[rx_rp_q[RAW-1:0]];
  assign rx_pop   = rd_data & ~rx_empty;

  // TX shifter
  st_e               tx_st_q;
  logic [OSW-1:0]    tx_os_q;
  logic [BW-1:0]     tx_bit_q;
  logic [DATA_W-1:0] tx_sh_q;
  logic              txd_q;
  logic              tx_idle;
`ifdef SPART_PARITY_EN
  logic              tx_par_q;
`endif

  // pop on the first tick out of IDLE, or straight from the
  // last stop tick for back-to-back characters
  assign tx_pop = tick & ~tx_empty &
                  ((tx_st_q == S_IDLE) |
                   ((tx_st_q == S_STOP) & (tx_os_q == OS_LAST)));
  assign tx_idle = (tx_st_q == S_IDLE) & tx_empty;

  // RX deserialiser
  st_e               rx_st_q;
  logic [OSW-1:0]    rx_os_q;
  logic [BW-1:0]     rx_bit_q;
  logic [DATA_W-1:0] rx_sh_q;
  logic              rx_fire;
  logic              rx_done;

  // START samples at half a bit; every later state at a full bit,
  // which lands each sample mid-bit
  assign rx_fire = tick & (rx_st_q != S_IDLE) &
                   (rx_os_q == ((rx_st_q == S_START) ? OS_MID : OS_LAST));
  assign rx_done = rx_fire & (rx_st_q == S_STOP);
  assign rx_push = rx_done & ~rx_full;

`ifdef SPART_PARITY_EN
  logic rx_perr;
  assign rx_perr = rx_fire & (rx_st_q == S_PAR) & (rx_s2_q != ^rx_sh_q);
`endif

  logic [15:0] status;
  assign status = {9'd0, pe_q, txo_q, fe_q, ovr_q,
                   tx_idle, ~tx_full, ~rx_empty};

  always_comb begin
    div_d     = wr_div ? bus.wdata : div_q;
    // a new divisor is only picked up here, at reload
    bcnt_d    = tick ? div_q : bcnt_q - 16'd1;
    ctrl_d    = wr_ctrl ? bus.wdata[1:0] : ctrl_q;
    rx_s1_d   = rxd;
    rx_s2_d   = rx_s1_q;
    rx_prev_d = rx_s2_q;

    tx_wp_d = tx_wp_q + {{TAW{1'b0}}, tx_push};
    tx_rp_d = tx_rp_q + {{TAW{1'b0}}, tx_pop};
    rx_wp_d = rx_wp_q + {{RAW{1'b0}}, rx_push};
    rx_rp_d = rx_rp_q + {{RAW{1'b0}}, rx_pop};

    // a set in the same cycle as a clear wins
    ovr_d = (ovr_q & ~(wr_stat & bus.wdata[3])) | (rx_done & rx_full);
    fe_d  = (fe_q & ~(wr_stat & bus.wdata[4])) | (rx_done & ~rx_s2_q);
    txo_d = (txo_q & ~(wr_stat & bus.wdata[5])) | (wr_data & tx_full);
`ifdef SPART_PARITY_EN
    pe_d  = (pe_q & ~(wr_stat & bus.wdata[6])) | rx_perr;
`else
    pe_d  = 1'b0;
`endif

    rdata_d = rdata_q;
    if (rd) begin
      unique case (bus.ioaddr)
        2'd0: begin
          rdata_d = '0;
          if (!rx_empty) rdata_d[DATA_W-1:0] = rx_head;
        end
        2'd1: rdata_d = status;
        2'd2: rdata_d = div_q;
        default: rdata_d = {14'd0, ctrl_q};
      endcase
    end

    irq_d = (ctrl_q[0] & ~rx_empty) | (ctrl_q[1] & tx_idle) |
            ovr_q | fe_q | pe_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q     <= DEFAULT_DIV;
      bcnt_q    <= '0;
      ctrl_q    <= '0;
      rdata_q   <= '0;
      irq_q     <= 1'b0;
      ovr_q     <= 1'b0;
      fe_q      <= 1'b0;
      txo_q     <= 1'b0;
      pe_q      <= 1'b0;
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
      tx_wp_q   <= '0;
      tx_rp_q   <= '0;
      rx_wp_q   <= '0;
      rx_rp_q   <= '0;
    end else begin
      div_q     <= div_d;
      bcnt_q    <= bcnt_d;
      ctrl_q    <= ctrl_d;
      rdata_q   <= rdata_d;
      irq_q     <= irq_d;
      ovr_q     <= ovr_d;
      fe_q      <= fe_d;
      txo_q     <= txo_d;
      pe_q      <= pe_d;
      rx_s1_q   <= rx_s1_d;
      rx_s2_q   <= rx_s2_d;
      rx_prev_q <= rx_prev_d;
      tx_wp_q   <= tx_wp_d;
      tx_rp_q   <= tx_rp_d;
      rx_wp_q   <= rx_wp_d;
      rx_rp_q   <= rx_rp_d;
    end
  end

  // FIFO storage needs no reset; pointers define validity
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp_q[TAW-1:0]] <= bus.wdata[DATA_W-1:0];
    if (rx_push) rx_mem[rx_wp_q[RAW-1:0]] <= rx_sh_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_st_q  <= S_IDLE;
      tx_os_q  <= '0;
      tx_bit_q <= '0;
      tx_sh_q  <= '0;
      txd_q    <= 1'b1;
`ifdef SPART_PARITY_EN
      tx_par_q <= 1'b0;
`endif
    end else if (tx_pop) begin
      tx_st_q <= S_START;
      tx_os_q <= '0;
      tx_sh_q <= tx_head;
      txd_q   <= 1'b0;
`ifdef SPART_PARITY_EN
      tx_par_q <= ^tx_head;
`endif
    end else if (tick && tx_st_q != S_IDLE) begin
      if (tx_os_q != OS_LAST) begin
        tx_os_q <= tx_os_q + 1'b1;
      end else begin
        tx_os_q <= '0;
        unique case (tx_st_q)
          S_START: begin
            tx_st_q  <= S_DATA;
            tx_bit_q <= '0;
            txd_q    <= tx_sh_q[0];
          end
          S_DATA: begin
            tx_bit_q <= tx_bit_q + 1'b1;
            tx_sh_q  <= tx_sh_q >> 1;
            if (tx_bit_q == B_LAST) begin
              tx_st_q <= AFTER_DATA;
`ifdef SPART_PARITY_EN
              txd_q   <= tx_par_q;
`else
              txd_q   <= 1'b1;
`endif
            end else begin
              txd_q <= tx_sh_q[1];
            end
          end
          S_PAR: begin
            tx_st_q <= S_STOP;
            txd_q   <= 1'b1;
          end
          default: begin
            tx_st_q <= S_IDLE;
            txd_q   <= 1'b1;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_st_q  <= S_IDLE;
      rx_os_q  <= '0;
      rx_bit_q <= '0;
      rx_sh_q  <= '0;
    end else if (rx_st_q == S_IDLE) begin
      if (rx_prev_q & ~rx_s2_q) begin
        rx_st_q <= S_START;
        rx_os_q <= '0;
      end
    end else if (tick) begin
      if (!rx_fire) begin
        rx_os_q <= rx_os_q + 1'b1;
      end else begin
        rx_os_q <= '0;
        unique case (rx_st_q)
          S_START: begin
            // line back high at mid-start: a glitch, not a start bit
            rx_st_q  <= rx_s2_q ? S_IDLE : S_DATA;
            rx_bit_q <= '0;
          end
          S_DATA: begin
            rx_sh_q  <= {rx_s2_q, rx_sh_q[DATA_W-1:1]};
            rx_bit_q <= rx_bit_q + 1'b1;
            if (rx_bit_q == B_LAST) rx_st_q <= AFTER_DATA;
          end
          S_PAR: rx_st_q <= S_STOP;
          // leave at mid-stop so the next start edge is not missed
          default: rx_st_q <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.rda   = ~rx_empty;
  assign bus.tbr   = ~tx_full;
  assign bus.irq   = irq_q;
  assign txd       = txd_q;

endmodule

// File: tb/tb_spart_fifo_core.sv
// tb_spart_fifo_core: directed bench for spart_fifo_core.
// Covers TX framing, loopback, FIFO overflow/overrun, glitch, framing.
module tb_spart_fifo_core;

`ifdef SPART_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic clk = 1'b0;
  logic rst;
  logic rxd_drv;
  logic lb;
  logic txd_w;
  logic rxd_w;
  logic [15:0] rv;
  logic [7:0]  exp_a5;
  int checks = 0;
  int errors = 0;

  spart_fifo_core_if bif();

  spart_fifo_core dut (
    .clk (clk),
    .rst (rst),
    .bus (bif),
    .txd (txd_w),
    .rxd (rxd_w)
  );

  assign rxd_w = lb ? txd_w : rxd_drv;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [15:0] d);
    @(negedge clk);
    bif.iocs = 1'b1;
    bif.iorw = 1'b0;
    bif.ioaddr = a;
    bif.wdata = d;
    @(negedge clk);
    bif.iocs = 1'b0;
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [15:0] d);
    @(negedge clk);
    bif.iocs = 1'b1;
    bif.iorw = 1'b1;
    bif.ioaddr = a;
    @(negedge clk);
    bif.iocs = 1'b0;
    d = bif.rdata;
  endtask

  task automatic wait_txd_low(input int bound);
    int n;
    n = 0;
    while (txd_w !== 1'b0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk("txd_fall", 16'(txd_w), 16'd0);
  endtask

  // 16 clocks per bit (divisor 0)
  task automatic send_frame(input logic [7:0] d, input logic stop);
    rxd_drv = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd_drv = d[i];
      repeat (16) @(negedge clk);
    end
`ifdef SPART_PARITY_EN
    rxd_drv = ^d;
    repeat (16) @(negedge clk);
`endif
    rxd_drv = stop;
    repeat (16) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (16) @(negedge clk);
  endtask

`ifdef SPART_PARITY_EN
  task automatic send_badpar(input logic [7:0] d);
    rxd_drv = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd_drv = d[i];
      repeat (16) @(negedge clk);
    end
    rxd_drv = ~(^d);
    repeat (16) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (32) @(negedge clk);
  endtask
`endif

  initial begin
    rst = 1'b1;
    rxd_drv = 1'b1;
    lb = 1'b0;
    bif.iocs = 1'b0;
    bif.iorw = 1'b0;
    bif.ioaddr = 2'd0;
    bif.wdata = 16'd0;
    exp_a5 = 8'hA5;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // reset state
    chk("rst_txd", 16'(txd_w), 16'd1);
    chk("rst_irq", 16'(bif.irq), 16'd0);
    chk("rst_rda", 16'(bif.rda), 16'd0);
    chk("rst_tbr", 16'(bif.tbr), 16'd1);
    chk("rst_rdata", bif.rdata, 16'd0);
    bus_rd(2'd1, rv);
    chk("rst_status", rv, 16'h0006);

    // TX framing of 0xA5 at one tick per clock
    bus_wr(2'd2, 16'd0);
    repeat (700) @(negedge clk);
    bus_wr(2'd0, 16'h00A5);
    wait_txd_low(40);
    repeat (8) @(negedge clk);
    chk("tx_start", 16'(txd_w), 16'd0);
    for (int i = 0; i < 8; i++) begin
      repeat (16) @(negedge clk);
      chk("tx_bit", 16'(txd_w), 16'(exp_a5[i]));
    end
`ifdef SPART_PARITY_EN
    repeat (16) @(negedge clk);
    chk("tx_par", 16'(txd_w), 16'd0);
`endif
    repeat (16) @(negedge clk);
    chk("tx_stop", 16'(txd_w), 16'd1);
    bus_rd(2'd1, rv);
    chk("tx_busy_status", rv, 16'h0002);
    repeat (10) @(negedge clk);
    bus_rd(2'd1, rv);
    chk("tx_done_status", rv, 16'h0006);

    // tx_ie interrupt
    bus_wr(2'd3, 16'hFFFE);
    @(negedge clk);
    chk("irq_tx_ie", 16'(bif.irq), 16'd1);
    bus_rd(2'd3, rv);
    chk("ctrl_rd", rv, 16'h0002);
    bus_wr(2'd3, 16'h0000);
    repeat (2) @(negedge clk);
    chk("irq_off", 16'(bif.irq), 16'd0);

    // loopback of three characters at divisor 3
    lb = 1'b1;
    bus_wr(2'd2, 16'd3);
    bus_rd(2'd2, rv);
    chk("div_rd", rv, 16'h0003);
    bus_wr(2'd0, 16'h003C);
    bus_wr(2'd0, 16'h00C3);
    bus_wr(2'd0, 16'h0000);
    repeat (2200) @(negedge clk);
    bus_rd(2'd1, rv);
    chk("lb_status", rv, 16'h0007);
    bus_rd(2'd0, rv);
    chk("lb_rd0", rv, 16'h003C);
    bus_rd(2'd0, rv);
    chk("lb_rd1", rv, 16'h00C3);
    bus_rd(2'd0, rv);
    chk("lb_rd2", rv, 16'h0000);
    chk("lb_rda", 16'(bif.rda), 16'd0);
    bus_rd(2'd0, rv);
    chk("rd_empty", rv, 16'h0000);
    lb = 1'b0;

    // TX overflow with a slow baud
    bus_wr(2'd2, 16'd650);
    repeat (10) @(negedge clk);
    for (int i = 0; i < 8; i++) bus_wr(2'd0, 16'(8'h40 + i));
    chk("tbr_full", 16'(bif.tbr), 16'd0);
    bus_wr(2'd0, 16'h0048);
    bus_rd(2'd1, rv);
    chk("txo_status", rv, 16'h0020);
    bus_wr(2'd1, 16'h0020);
    bus_rd(2'd1, rv);
    chk("txo_clear", rv, 16'h0000);

    // reset in the middle of a frame
    wait_txd_low(1500);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_txd", 16'(txd_w), 16'd1);
    rst = 1'b0;
    bus_rd(2'd1, rv);
    chk("rst_mid_status", rv, 16'h0006);

    // RX overrun
    bus_wr(2'd2, 16'd0);
    repeat (700) @(negedge clk);
    for (int i = 0; i < 9; i++) send_frame(8'h10 + 8'(i), 1'b1);
    bus_rd(2'd1, rv);
    chk("ovr_status", rv, 16'h000F);
    chk("ovr_irq", 16'(bif.irq), 16'd1);
    for (int i = 0; i < 8; i++) begin
      bus_rd(2'd0, rv);
      chk("ovr_rd", rv, 16'(8'h10 + i));
    end
    chk("ovr_rda", 16'(bif.rda), 16'd0);
    bus_wr(2'd1, 16'h0078);
    repeat (2) @(negedge clk);
    chk("ovr_irq_clr", 16'(bif.irq), 16'd0);

    // glitch on idle line
    rxd_drv = 1'b0;
    repeat (2) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (40) @(negedge clk);
    chk("glitch_rda", 16'(bif.rda), 16'd0);
    bus_rd(2'd1, rv);
    chk("glitch_status", rv, 16'h0006);

    // framing error
    send_frame(8'h55, 1'b0);
    bus_rd(2'd1, rv);
    chk("fe_status", rv, 16'h0017);
    bus_rd(2'd0, rv);
    chk("fe_data", rv, 16'h0055);
    bus_wr(2'd1, 16'h0010);

`ifdef SPART_PARITY_EN
    send_badpar(8'h01);
    bus_rd(2'd1, rv);
    chk("pe_status", rv, 16'h0047);
    bus_rd(2'd0, rv);
    chk("pe_data", rv, 16'h0001);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spart_fifo_core.md
Name: spart_fifo_core

Overview:
Parametrised next-generation SPART: full-duplex asynchronous serial transceiver with a programmable baud divisor, configurable character width and separate TX/RX FIFOs. It sits behind the same iocs/iorw/ioaddr processor-side bus used by the existing driver. It replaces the single-byte buffered SPART so the driver can burst multiple characters without polling tbr/rda per byte.

Parameters:
DATA_W, 8, character width in bits; legal range 5..9.
TX_DEPTH, 8, TX FIFO entries; power of 2, at least 2.
RX_DEPTH, 8, RX FIFO entries; power of 2, at least 2.
OVERSAMPLE, 16, baud ticks per bit; even, at least 4.
DEFAULT_DIV, 16'd650, divisor loaded at reset (9600 baud at 100 MHz, x16).

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
iocs  in  1  chip select; one access per cycle it is high
iorw  in  1  1 = read, 0 = write
ioaddr  in  2  register select
wdata  in  16  write data
rdata  out  16  registered read data
rda  out  1  RX FIFO not empty
tbr  out  1  TX FIFO not full
irq  out  1  interrupt request
txd  out  1  serial transmit, idle high
rxd  in  1  serial receive, asynchronous

Behaviour:
- Reset values: txd=1, rdata=0, rda=0, tbr=1, irq=0. Both FIFOs empty, divisor=DEFAULT_DIV, control=0, sticky flags=0.
- Register map:
  - Address 0 DATA. Write pushes wdata[DATA_W-1:0] into the TX FIFO. Read pops the RX FIFO head.
  - Address 1 STATUS, read-only bits: [0] rda, [1] tbr, [2] tx_idle (TX FIFO empty and shifter idle), [3] rx_overrun, [4] framing_err, [5] tx_overflow, [6] parity_err. Writing address 1 clears each sticky bit whose wdata bit is 1.
  - Address 2 DIVISOR, read/write.
  - Address 3 CONTROL, read/write: [0] rx_ie, [1] tx_ie. Other bits read 0.
- Read latency: rdata updates on the clock edge after the access and holds until the next read. DATA read with the FIFO empty returns 0 and does not move the pointers. Unused upper rdata bits are 0.
- Write to DATA with the TX FIFO full: data dropped, tx_overflow set.
- Baud generator:
  - Down-counter reloads from DIVISOR; one tick every DIVISOR+1 clocks.
  - A DIVISOR write takes effect at the next reload. An in-flight count is not truncated.
- TX FSM: IDLE -> START -> DATA (DATA_W bits, LSB first) -> [PARITY] -> STOP -> IDLE.
  - Each state lasts OVERSAMPLE ticks.
  - IDLE leaves on the first tick after the FIFO becomes non-empty. The pop occurs on entry to START.
  - Back-to-back characters: STOP goes directly to START when the FIFO is non-empty.
- RX path:
  - rxd passes through a 2-flop synchroniser.
  - FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - IDLE->START on a sampled falling edge.
  - At tick OVERSAMPLE/2 of START, if the line is high the start is false: return to IDLE, no flags.
  - Data, parity and stop bits are each sampled at mid-bit.
  - Stop sampled 0: framing_err set, character still pushed.
  - RX FIFO full at stop: character dropped, rx_overrun set.
  - After STOP the FSM returns to IDLE at mid-stop so the next start edge is caught.
- Simultaneous events:
  - RX push and a DATA-read pop in the same cycle on a non-empty FIFO are both performed; count is unchanged.
  - Same rule for TX write and shifter pop.
  - A sticky clear and a set of the same bit in the same cycle: set wins.
- irq = (rx_ie & rda) | (tx_ie & tx_idle) | rx_overrun | framing_err | parity_err. Registered, one cycle after cause.
- Reset mid-frame aborts the frame. txd is high on the next edge and no partial character is pushed.

Optional Feature:
SPART_PARITY_EN.
- Defined: an even-parity bit is inserted after the data bits on TX and checked on RX. A mismatch sets parity_err (the character is still pushed).
- Undefined: no parity state, frame is start + DATA_W + stop, and STATUS[6] reads 0.

Test Plan:
- Reset, then read STATUS -> rdata=16'h0006, txd=1, irq=0.
- DIVISOR=0, write DATA 8'hA5 -> txd low for 16 clocks, then bits 1,0,1,0,0,1,0,1 of 16 clocks each, then stop high. tx_idle returns to 1 after 160 clocks (no parity).
- Loopback txd->rxd, DIVISOR=3, write 8'h3C, 8'hC3, 8'h00 -> three RX characters; reads return 16'h003C, 16'h00C3, 16'h0000, then rda=0.
- Write 9 bytes with TX_DEPTH=8 while DIVISOR=650 -> 9th dropped, STATUS[5]=1. Write 16'h0020 to address 1 -> bit cleared.
- Drive 9 frames into rxd without reading -> 8 stored, rx_overrun=1, irq=1. A 2-clock glitch low on idle rxd -> no character, no flags.
- Stop bit forced low on 8'h55 -> character pushed, framing_err=1. With SPART_PARITY_EN, a wrong parity bit on 8'h01 -> parity_err=1.
